// File: rtl/pmod_button_reader.sv
// pmod_button_reader
// Samples WIDTH buttons/switches from a PMOD header. Each channel is
// synchronised to CLK_48 and debounced on its own. The outputs are clean
// levels, one-cycle press/release pulses, and sticky press flags.
//
// Ports:
//   CLK_48      in   system clock (48 MHz)
//   reset       in   synchronous active-high reset
//   pmod_in     in   [WIDTH] raw asynchronous pin levels
//   clear       in   [WIDTH] write-1-to-clear for press_latch
//   state       out  [WIDTH] debounced level, 1 = pressed
//   pressed     out  [WIDTH] one-cycle pulse on a 0->1 change of state
//   released    out  [WIDTH] one-cycle pulse on a 1->0 change of state
//   press_latch out  [WIDTH] sticky flag, set by pressed, cleared by clear

// Per-channel synchroniser, debouncer and sticky flag.
module pmod_button_chan #(
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,     // logical level, 1 = pressed
    input  logic i_clear,
    output logic o_state,
    output logic o_pressed,
    output logic o_released,
    output logic o_latch
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1, r_s2;
    logic          r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pressed, r_released, r_latch;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_state    <= 1'b0;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_latch    <= 1'b0;
        end else begin
            r_s1       <= i_level;
            r_s2       <= r_s1;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;

            // Any cycle where the synchronised level agrees with the
            // accepted state restarts the stability count.
            if (r_s2 == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_state    <= r_s2;
                r_cnt      <= '0;
                r_pressed  <= r_s2;
                r_released <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Set comes from the registered pulse, so it lands one cycle
            // after pressed and beats a clear arriving in that same cycle.
            if (r_pressed)
                r_latch <= 1'b1;
            else if (i_clear)
                r_latch <= 1'b0;
        end
    end

    assign o_state    = r_state;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    assign o_latch    = r_latch;
endmodule

module pmod_button_reader #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             CLK_48,
    input  logic             reset,
    input  logic [WIDTH-1:0] pmod_in,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] press_latch
);
    localparam logic [WIDTH-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

    // Everything past this point works on logical levels (1 = pressed).
    logic [WIDTH-1:0] w_level;
    assign w_level = pmod_in ^ POL;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        pmod_button_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk     (CLK_48),
            .i_rst     (reset),
            .i_level   (w_level[g]),
            .i_clear   (clear[g]),
            .o_state   (state[g]),
            .o_pressed (pressed[g]),
            .o_released(released[g]),
            .o_latch   (press_latch[g])
        );
    end
endmodule
